// File: rtl/wb_sdram_port.sv
// wb_sdram_port: 32-bit Wishbone slave in front of the SDRAM controller's
// 16-bit access port. Writes go through as one or two halfword writes. Reads
// are served from a single 16-byte line that one 8-beat burst fills, and
// write hits keep that line coherent.
module wb_sdram_port #(
  parameter int BURST_LENGTH = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        sdram_acc_o,
  output logic [31:0] sdram_adr_o,
  output logic [15:0] sdram_dat_o,
  output logic [1:0]  sdram_sel_o,
  output logic        sdram_we_o,
  input  logic        sdram_ack_i,
  input  logic [31:0] sdram_adr_i,
  input  logic [15:0] sdram_dat_i
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WR_HI = 3'd2;
  localparam logic [2:0] ST_WR_LO = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;

  logic [2:0]  state;
  logic [31:2] adr_q;       // latched word address
  logic [15:0] dat_lo_q;    // lower halfword, needed after the upper write
  logic [1:0]  sel_lo_q;
  logic        we_q;
  logic        acc_q;
  logic        fill_run;    // beats are streaming; controller ack no longer matters
  logic [2:0]  beat_cnt;
  logic [27:0] tag_q;
  logic        valid_q;
  logic [15:0] line_buf [0:7];

  logic req;
  logic hit;
  logic fill_cap;
  logic wt_en;
  logic [2:0] idx_hi;
  logic [2:0] idx_lo;
  logic unused_bits;

  assign req      = wb_cyc_i & wb_stb_i;
  assign hit      = valid_q & (tag_q == wb_adr_i[31:4]);
  assign fill_cap = (state == ST_FILL) & (fill_run | sdram_ack_i);
  assign wt_en    = (state == ST_IDLE) & req & wb_we_i & hit;
  assign idx_hi   = {wb_adr_i[3:2], 1'b0};
  assign idx_lo   = {wb_adr_i[3:2], 1'b1};

  // Request drops in the controller's ack cycle so it never sees a repeat.
  assign sdram_acc_o = acc_q & ~sdram_ack_i;
  assign wb_ack_o    = (state == ST_ACK);

  // Bits that carry no information for this port.
  assign unused_bits = ^{wb_adr_i[1:0], sdram_adr_i[31:4], sdram_adr_i[0]};

  // Read data is presented only during the ack cycle of a read; the line is
  // small enough to read combinationally, so the last burst beat is visible.
  always_comb begin
    wb_dat_o = '0;
    if (state == ST_ACK && !we_q)
      wb_dat_o = {line_buf[{adr_q[3:2], 1'b0}], line_buf[{adr_q[3:2], 1'b1}]};
  end

  // Line buffer: burst beats land at the index the controller reports, so a
  // wrapped burst order fills the line correctly. Write hits merge bytes.
  always_ff @(posedge sdram_clk) begin
    if (fill_cap) begin
      line_buf[sdram_adr_i[3:1]] <= sdram_dat_i;
    end else if (wt_en) begin
      for (int b = 0; b < 2; b++) begin
        if (wb_sel_i[2+b]) line_buf[idx_hi][8*b +: 8] <= wb_dat_i[16+8*b +: 8];
        if (wb_sel_i[b])   line_buf[idx_lo][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // Transaction sequencer: latches the bus request, runs the controller
  // handshakes and the burst fill, then issues a single-cycle bus ack.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state       <= ST_IDLE;
      adr_q       <= '0;
      dat_lo_q    <= '0;
      sel_lo_q    <= '0;
      we_q        <= 1'b0;
      acc_q       <= 1'b0;
      fill_run    <= 1'b0;
      beat_cnt    <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      sdram_adr_o <= '0;
      sdram_dat_o <= '0;
      sdram_sel_o <= '0;
      sdram_we_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            adr_q    <= wb_adr_i[31:2];
            dat_lo_q <= wb_dat_i[15:0];
            sel_lo_q <= wb_sel_i[1:0];
            we_q     <= wb_we_i;
            if (!wb_we_i) begin
              if (hit) begin
                state <= ST_ACK;
              end else begin
                state       <= ST_FILL;
                acc_q       <= 1'b1;
                fill_run    <= 1'b0;
                valid_q     <= 1'b0;
                sdram_we_o  <= 1'b0;
                sdram_sel_o <= 2'b11;
                sdram_adr_o <= {wb_adr_i[31:4], 4'b0000};
              end
            end else if (wb_sel_i[3:2] != 2'b00) begin
              state       <= ST_WR_HI;
              acc_q       <= 1'b1;
              sdram_we_o  <= 1'b1;
              sdram_dat_o <= wb_dat_i[31:16];
              sdram_sel_o <= wb_sel_i[3:2];
              sdram_adr_o <= {wb_adr_i[31:2], 2'b00};
            end else if (wb_sel_i[1:0] != 2'b00) begin
              state       <= ST_WR_LO;
              acc_q       <= 1'b1;
              sdram_we_o  <= 1'b1;
              sdram_dat_o <= wb_dat_i[15:0];
              sdram_sel_o <= wb_sel_i[1:0];
              sdram_adr_o <= {wb_adr_i[31:2], 2'b10};
            end else begin
              state <= ST_ACK;
            end
          end
        end
        ST_FILL: begin
          if (fill_run) begin
            if (beat_cnt == 3'(BURST_LENGTH - 1)) begin
              fill_run <= 1'b0;
              tag_q    <= adr_q[31:4];
              valid_q  <= 1'b1;
              state    <= ST_ACK;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end else if (sdram_ack_i) begin
            acc_q    <= 1'b0;
            fill_run <= 1'b1;
            beat_cnt <= 3'd1;
          end
        end
        ST_WR_HI: begin
          if (sdram_ack_i) begin
            acc_q <= 1'b0;
            state <= (sel_lo_q != 2'b00) ? ST_WR_LO : ST_ACK;
          end
        end
        ST_WR_LO: begin
          // Arriving from WR_HI, acc_q is low for one cycle before re-raising.
          if (!acc_q) begin
            acc_q       <= 1'b1;
            sdram_dat_o <= dat_lo_q;
            sdram_sel_o <= sel_lo_q;
            sdram_adr_o <= {adr_q, 2'b10};
          end else if (sdram_ack_i) begin
            acc_q <= 1'b0;
            state <= ST_ACK;
          end
        end
        ST_ACK: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_port.sv
// tb_wb_sdram_port: directed table of Wishbone transactions against a small
// behavioural SDRAM controller, plus hand-written write-log and reset checks.
module tb_wb_sdram_port;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sdram_acc_o;
  logic [31:0] sdram_adr_o;
  logic [15:0] sdram_dat_o;
  logic [1:0]  sdram_sel_o;
  logic        sdram_we_o;
  logic        sdram_ack_i = 1'b0;
  logic [31:0] sdram_adr_i = '0;
  logic [15:0] sdram_dat_i = '0;

  wb_sdram_port #(.BURST_LENGTH(8)) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .sdram_acc_o (sdram_acc_o),
    .sdram_adr_o (sdram_adr_o),
    .sdram_dat_o (sdram_dat_o),
    .sdram_sel_o (sdram_sel_o),
    .sdram_we_o  (sdram_we_o),
    .sdram_ack_i (sdram_ack_i),
    .sdram_adr_i (sdram_adr_i),
    .sdram_dat_i (sdram_dat_i)
  );

  always #5 sdram_clk = ~sdram_clk;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  always @(posedge sdram_clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural controller ----------------
  logic [15:0] mem [logic [31:0]];
  int          n_rd = 0;
  int          n_wr = 0;
  int          last_ack_edge = 0;
  int          beat_idx = -1;
  int          wrap_start = 0;
  logic [31:0] last_rd_adr = '0;
  logic [31:0] wlog_adr [$];
  logic [15:0] wlog_dat [$];
  logic [1:0]  wlog_sel [$];

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {4'hA, a[11:0]};
  endfunction

  // Accepts one access at a time: two wait cycles, then ack (write) or an
  // 8-beat burst whose first beat carries the ack (read).
  always begin : ctrl_model
    logic [31:0] a;
    logic        w;
    logic [15:0] d;
    logic [15:0] v;
    logic [1:0]  s;
    logic [2:0]  bi;
    @(posedge sdram_clk); #1;
    if (sdram_acc_o === 1'b1) begin
      a = sdram_adr_o; w = sdram_we_o; d = sdram_dat_o; s = sdram_sel_o;
      repeat (2) begin @(posedge sdram_clk); #1; end
      last_ack_edge = edge_cnt;
      if (w) begin
        sdram_ack_i = 1'b1;
        #1 check("acc_low_in_wr_ack", {31'd0, sdram_acc_o}, 32'd0);
        n_wr++;
        wlog_adr.push_back(a); wlog_dat.push_back(d); wlog_sel.push_back(s);
        v = mem_rd(a);
        if (s[1]) v[15:8] = d[15:8];
        if (s[0]) v[7:0]  = d[7:0];
        mem[a] = v;
        @(posedge sdram_clk); #1;
        sdram_ack_i = 1'b0;
        check("acc_low_after_wr_ack", {31'd0, sdram_acc_o}, 32'd0);
      end else begin
        n_rd++;
        last_rd_adr = a;
        for (int i = 0; i < 8; i++) begin
          beat_idx    = i;
          bi          = 3'((wrap_start + i) % 8);
          sdram_ack_i = (i == 0);
          sdram_adr_i = {a[31:4], bi, 1'b0};
          sdram_dat_i = mem_rd(sdram_adr_i);
          if (i == 0) #1 check("acc_low_in_rd_ack", {31'd0, sdram_acc_o}, 32'd0);
          @(posedge sdram_clk); #1;
        end
        sdram_ack_i = 1'b0;
        beat_idx    = -1;
      end
    end
  end

  // ---------------- Wishbone master ----------------
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output int stb_edge, output int ack_edge);
    bit ok;
    ok = 0; rdat = '0; ack_edge = 0;
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    stb_edge = edge_cnt;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge sdram_clk);
      if (wb_ack_o === 1'b1) begin
        ok = 1; rdat = wb_dat_o; ack_edge = edge_cnt;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ack_timeout: adr %h got no ack expected ack within 200 cycles", adr);
    end
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge sdram_clk);
    check("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wrap;
    logic [31:0] exp_dat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [16];

  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } wexp_t;

  wexp_t wexp [6];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_ack"},  {31'd0, wb_ack_o}, 32'd0);
    check({tag, "_wb_dat"},  wb_dat_o, 32'd0);
    check({tag, "_acc"},     {31'd0, sdram_acc_o}, 32'd0);
    check({tag, "_we"},      {31'd0, sdram_we_o}, 32'd0);
    check({tag, "_sel"},     {30'd0, sdram_sel_o}, 32'd0);
    check({tag, "_adr"},     sdram_adr_o, 32'd0);
    check({tag, "_dat"},     {16'd0, sdram_dat_o}, 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation got no finish expected finish before 300000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rdat;
    int          stb_edge, ack_edge, rd0, wr0, lat;
    bit          found;

    //          we  adr     dat            sel   wrap exp_dat        rd wr
    vecs[0]  = '{0, 32'h10, 32'h0,        4'hF, 0, 32'h11112222, 1, 0};
    vecs[1]  = '{0, 32'h1C, 32'h0,        4'hF, 0, 32'h77778888, 0, 0};
    vecs[2]  = '{1, 32'h20, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 2};
    vecs[3]  = '{1, 32'h14, 32'h0000ABCD, 4'h3, 0, 32'h0,        0, 1};
    vecs[4]  = '{0, 32'h14, 32'h0,        4'hF, 0, 32'h3333ABCD, 0, 0};
    vecs[5]  = '{1, 32'h30, 32'h55555555, 4'h0, 0, 32'h0,        0, 0};
    vecs[6]  = '{0, 32'h20, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1, 0};
    vecs[7]  = '{0, 32'h2C, 32'h0,        4'hF, 0, 32'hA02CA02E, 0, 0};
    vecs[8]  = '{1, 32'h24, 32'h12345678, 4'hC, 0, 32'h0,        0, 1};
    vecs[9]  = '{0, 32'h24, 32'h0,        4'hF, 0, 32'h1234A026, 0, 0};
    vecs[10] = '{1, 32'h28, 32'hAABBCCDD, 4'h9, 0, 32'h0,        0, 2};
    vecs[11] = '{0, 32'h28, 32'h0,        4'hF, 0, 32'hAA28A0DD, 0, 0};
    vecs[12] = '{0, 32'h14, 32'h0,        4'hF, 3, 32'h3333ABCD, 1, 0};
    vecs[13] = '{0, 32'h10, 32'h0,        4'hF, 0, 32'h11112222, 0, 0};
    vecs[14] = '{0, 32'h1C, 32'h0,        4'hF, 0, 32'h77778888, 0, 0};
    vecs[15] = '{0, 32'h18, 32'h0,        4'hF, 0, 32'h55556666, 0, 0};

    wexp[0] = '{32'h20, 16'hDEAD, 2'b11};
    wexp[1] = '{32'h22, 16'hBEEF, 2'b11};
    wexp[2] = '{32'h16, 16'hABCD, 2'b11};
    wexp[3] = '{32'h24, 16'h1234, 2'b11};
    wexp[4] = '{32'h28, 16'hAABB, 2'b10};
    wexp[5] = '{32'h2A, 16'hCCDD, 2'b01};

    mem[32'h10] = 16'h1111; mem[32'h12] = 16'h2222;
    mem[32'h14] = 16'h3333; mem[32'h16] = 16'h4444;
    mem[32'h18] = 16'h5555; mem[32'h1A] = 16'h6666;
    mem[32'h1C] = 16'h7777; mem[32'h1E] = 16'h8888;

    sdram_rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    check_reset_outputs("reset_held");
    sdram_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wrap_start = vecs[i].wrap;
      rd0 = n_rd; wr0 = n_wr;
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rdat, stb_edge, ack_edge);
      if (vecs[i].exp_rd > 0 || vecs[i].exp_wr > 0) lat = ack_edge - last_ack_edge;
      else lat = ack_edge - stb_edge;
      $display("vec %0d we=%0d adr=%h sel=%h rdat=%h lat=%0d rd=%0d wr=%0d", i, vecs[i].we,
               vecs[i].adr, vecs[i].sel, rdat, lat, n_rd - rd0, n_wr - wr0);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_dat);
      check($sformatf("v%0d_ctrl_reads", i), n_rd - rd0, vecs[i].exp_rd);
      check($sformatf("v%0d_ctrl_writes", i), n_wr - wr0, vecs[i].exp_wr);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].exp_rd > 0) ? 8 : 1);
      if (vecs[i].exp_rd > 0)
        check($sformatf("v%0d_fill_adr", i), last_rd_adr, {vecs[i].adr[31:4], 4'h0});
    end

    check("write_log_size", wlog_adr.size(), 6);
    if (wlog_adr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("wlog%0d_adr", i), wlog_adr[i], wexp[i].adr);
        check($sformatf("wlog%0d_dat", i), {16'd0, wlog_dat[i]}, {16'd0, wexp[i].dat});
        check($sformatf("wlog%0d_sel", i), {30'd0, wlog_sel[i]}, {30'd0, wexp[i].sel});
      end
    end

    // Reset during the fourth beat of a fill; the stale beats that follow
    // must be ignored and the same address must refill afterwards.
    wrap_start = 0;
    rd0 = n_rd;
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h40; wb_sel_i = 4'hF;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge sdram_clk); #2;
      if (beat_idx == 3) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL fill_beat4_timeout: got no beat 4 expected beat 4 within 100 cycles");
    end
    sdram_rst = 1'b1;
    #1 check_reset_outputs("reset_mid_fill");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge sdram_clk);
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    $display("reset mid fill applied at beat 4");

    wb_xfer(1'b0, 32'h40, 32'h0, 4'hF, rdat, stb_edge, ack_edge);
    lat = ack_edge - last_ack_edge;
    $display("refill adr=00000040 rdat=%h lat=%0d rd=%0d", rdat, lat, n_rd - rd0);
    check("refill_rdata", rdat, 32'hA040A042);
    check("refill_ctrl_reads", n_rd - rd0, 2);
    check("refill_latency", lat, 8);
    wb_xfer(1'b0, 32'h4C, 32'h0, 4'hF, rdat, stb_edge, ack_edge);
    $display("hit after refill adr=0000004c rdat=%h lat=%0d", rdat, ack_edge - stb_edge);
    check("refill_hit_rdata", rdat, 32'hA04CA04E);
    check("refill_hit_latency", ack_edge - stb_edge, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
